frame_receiver: RTL and testbench

Serial-line receiver directly upstream of the parity decoder in the transceiver receive path. Oversamples a single asynchronous `rx` line, detects start bits, and samples 8 data bits (LSB first), one parity bit and one stop bit. It presents the assembled 9-bit frame `{parity, data}` on the decoder's `in` bus with a one-cycle valid strobe. Parity is passed through unchecked; the decoder owns the parity check. This block owns line framing, glitch rejection and stop-bit errors.

---
 rtl/transceiver_pkg.sv | 24 ++
 rtl/sync_2ff.sv | 32 +++
 rtl/frame_receiver.sv | 184 ++++++++++++++++++
 tb/tb_frame_receiver.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/transceiver_pkg.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | transceiver_pkg                                                        |
// | Shared types and frame-layout constants for the transceiver path.      |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
package transceiver_pkg;

    localparam int unsigned RX_DATA_WIDTH = 8;
    localparam int unsigned FRAME_WIDTH   = RX_DATA_WIDTH + 1;
    // Position of the parity bit inside the frame handed to the decoder.
    localparam int unsigned PARITY_POS    = RX_DATA_WIDTH;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_START     = 3'd1,
        ST_DATA      = 3'd2,
        ST_PARITY    = 3'd3,
        ST_STOP      = 3'd4,
        ST_WAIT_IDLE = 3'd5
    } rx_state_t;

endpackage
`default_nettype wire

// File: rtl/sync_2ff.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | sync_2ff                                                               |
// | Generic two-flop synchronizer with a parameterized reset value.        |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
module sync_2ff #(
    parameter logic RESET_VALUE = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            meta_q <= RESET_VALUE;
            sync_q <= RESET_VALUE;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;

endmodule
`default_nettype wire

// File: rtl/frame_receiver.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | frame_receiver                                                         |
// | Oversampling serial receiver: start, DATA_WIDTH data bits (LSB first), |
// | parity and stop; emits {parity, data} with a valid or error strobe.    |
// | Optional: FRAME_RX_MAJORITY_EN enables 2-of-3 majority sampling.       |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
module frame_receiver
    import transceiver_pkg::*;
#(
    parameter int unsigned DATA_WIDTH   = RX_DATA_WIDTH,
    parameter int unsigned CLKS_PER_BIT = 16
) (
    input  logic                clk,
    input  logic                arst_n,
    input  logic                rx,
    output logic [DATA_WIDTH:0] out_frame,
    output logic                out_valid,
    output logic                frame_err,
    output logic                busy
);

    localparam int unsigned HALF  = CLKS_PER_BIT / 2;
    localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
    localparam int unsigned IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_WIDTH - 1);

    logic rx_s;
    logic sample;

    sync_2ff #(
        .RESET_VALUE (1'b1)
    ) u_rx_sync (
        .clk   (clk),
        .rst_n (arst_n),
        .d     (rx),
        .q     (rx_s)
    );

`ifdef FRAME_RX_MAJORITY_EN
    // Decision is taken one edge after the nominal point, so the three votes
    // are rx_s at nominal-1, nominal and nominal+1.
    localparam logic [CNT_W-1:0] CNT_START = CNT_W'(HALF);

    logic [1:0] hist_q;
    logic [1:0] hist_d;

    assign hist_d = {hist_q[0], rx_s};
    assign sample = (hist_q[1] & hist_q[0]) | (hist_q[1] & rx_s) | (hist_q[0] & rx_s);

    always_ff @(posedge clk) begin
        if (!arst_n) begin
            hist_q <= 2'b11;
        end else begin
            hist_q <= hist_d;
        end
    end
`else
    localparam logic [CNT_W-1:0] CNT_START = CNT_W'(HALF - 1);

    assign sample = rx_s;
`endif

    rx_state_t             state_q,  state_d;
    logic [CNT_W-1:0]      cnt_q,    cnt_d;
    logic [IDX_W-1:0]      idx_q,    idx_d;
    logic [DATA_WIDTH-1:0] shreg_q,  shreg_d;
    logic                  parity_q, parity_d;
    logic [DATA_WIDTH:0]   frame_q,  frame_d;
    logic                  valid_q,  valid_d;
    logic                  err_q,    err_d;
    logic                  busy_q,   busy_d;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        shreg_d  = shreg_q;
        parity_d = parity_q;
        frame_d  = frame_q;
        valid_d  = 1'b0;
        err_d    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (!rx_s) begin
                    state_d = ST_START;
                    cnt_d   = '0;
                end
            end
            ST_START: begin
                if (cnt_q == CNT_START) begin
                    cnt_d = '0;
                    idx_d = '0;
                    state_d = sample ? ST_IDLE : ST_DATA;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_DATA: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d          = '0;
                    shreg_d[idx_q] = sample;
                    if (idx_q == IDX_LAST) begin
                        state_d = ST_PARITY;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_PARITY: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d    = '0;
                    parity_d = sample;
                    state_d  = ST_STOP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_STOP: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    frame_d = {parity_q, shreg_q};
                    if (sample) begin
                        valid_d = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        // A break must yield a single error, so park until the line idles.
                        err_d   = 1'b1;
                        state_d = ST_WAIT_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_WAIT_IDLE: begin
                if (rx_s) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (!arst_n) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            idx_q    <= '0;
            shreg_q  <= '0;
            parity_q <= 1'b0;
            frame_q  <= '0;
            valid_q  <= 1'b0;
            err_q    <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            shreg_q  <= shreg_d;
            parity_q <= parity_d;
            frame_q  <= frame_d;
            valid_q  <= valid_d;
            err_q    <= err_d;
            busy_q   <= busy_d;
        end
    end

    assign out_frame = frame_q;
    assign out_valid = valid_q;
    assign frame_err = err_q;
    assign busy      = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_frame_receiver.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | tb_frame_receiver                                                      |
// | Directed and randomized frames checked against an event-level model.   |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
module tb_frame_receiver;
    import transceiver_pkg::*;

    localparam int DW   = 8;
    localparam int CPB  = 16;
    localparam int HALF = CPB / 2;
`ifdef FRAME_RX_MAJORITY_EN
    localparam int EXTRA = 1;
`else
    localparam int EXTRA = 0;
`endif
    // Edge of the strobe relative to the first edge that registers the start bit.
    localparam int LAT        = 2 + HALF + (DW + 2) * CPB + EXTRA;
    localparam int START_EXIT = 2 + HALF + EXTRA;
    localparam int LOGN       = 8192;

    logic          clk = 1'b0;
    logic          arst_n;
    logic          rx;
    logic [DW:0]   out_frame;
    logic          out_valid;
    logic          frame_err;
    logic          busy;

    frame_receiver #(
        .DATA_WIDTH   (DW),
        .CLKS_PER_BIT (CPB)
    ) dut (
        .clk       (clk),
        .arst_n    (arst_n),
        .rx        (rx),
        .out_frame (out_frame),
        .out_valid (out_valid),
        .frame_err (frame_err),
        .busy      (busy)
    );

    typedef struct {
        int          cyc;
        logic [DW:0] frame;
        bit          err;
    } ev_t;

    ev_t         exp_q[$];
    ev_t         obs_q[$];
    int          cyc = 0;
    int          checks = 0;
    int          failures = 0;
    int          both_cnt = 0;
    bit          busy_log [LOGN];
    logic [DW:0] last_frame = '0;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (cyc < LOGN) busy_log[cyc] = busy;
        if (out_valid && frame_err) both_cnt++;
        if (out_valid || frame_err) obs_q.push_back('{cyc: cyc, frame: out_frame, err: frame_err});
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_busy(input string tag, input int c, input bit exp);
        chk(tag, (c >= 0 && c < LOGN) ? 32'(busy_log[c]) : 32'hDEAD, 32'(exp));
    endtask

    task automatic idle(input int n);
        rx = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    // Drives one 11-bit frame and records what the receiver must report for it.
    task automatic send_frame(input logic [DW-1:0] data, input logic par, input logic stop,
                              input int rst_bit, output int e0);
        logic [DW:0] f;
        rx = 1'b0;
        e0 = cyc + 1;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < DW; i++) begin
            rx = data[i];
            if (i == rst_bit) begin
                repeat (5) @(negedge clk);
                arst_n = 1'b0;
                @(negedge clk);
                arst_n = 1'b1;
                repeat (CPB - 6) @(negedge clk);
            end else begin
                repeat (CPB) @(negedge clk);
            end
        end
        rx = par;
        repeat (CPB) @(negedge clk);
        rx = stop;
        repeat (CPB) @(negedge clk);
        rx = 1'b1;
        f = '0;
        f[DW-1:0] = data;
        f[PARITY_POS] = par;
        if (rst_bit < 0) begin
            exp_q.push_back('{cyc: e0 + LAT, frame: f, err: !stop});
            last_frame = f;
        end else begin
            last_frame = '0;
        end
    endtask

    task automatic compare_events(input string tag);
        chk({tag, "_count"}, 32'(obs_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            chk($sformatf("%s_cyc%0d", tag, i), 32'(obs_q[i].cyc), 32'(exp_q[i].cyc));
            chk($sformatf("%s_frame%0d", tag, i), 32'(obs_q[i].frame), 32'(exp_q[i].frame));
            chk($sformatf("%s_err%0d", tag, i), 32'(obs_q[i].err), 32'(exp_q[i].err));
        end
        obs_q.delete();
        exp_q.delete();
        chk({tag, "_hold"}, 32'(out_frame), 32'(last_frame));
    endtask

    initial begin
        int e0;
        int e1;
        int gap;
        bit prev_stop;
        logic [DW-1:0] d;
        logic p;
        logic s;

        rx = 1'b1;
        arst_n = 1'b0;
        repeat (4) begin
            @(negedge clk);
            rx = ~rx;
        end
        chk("rst_out_frame", 32'(out_frame), 32'h0);
        chk("rst_out_valid", 32'(out_valid), 32'h0);
        chk("rst_frame_err", 32'(frame_err), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        @(negedge clk);
        arst_n = 1'b1;
        idle(6);
        compare_events("post_reset");

        send_frame(8'hA5, 1'b0, 1'b1, -1, e0);
        idle(4);
        chk_busy("single_busy_pre", e0 + 1, 1'b0);
        chk_busy("single_busy_rise", e0 + 2, 1'b1);
        chk_busy("single_busy_late", e0 + LAT - 1, 1'b1);
        chk_busy("single_busy_fall", e0 + LAT, 1'b0);
        compare_events("single");

        send_frame(8'h3C, 1'b0, 1'b1, -1, e0);
        send_frame(8'hFF, 1'b1, 1'b1, -1, e1);
        idle(4);
        if (obs_q.size() == 2)
            chk("b2b_spacing", 32'(obs_q[1].cyc - obs_q[0].cyc), 32'(e1 - e0));
        chk("b2b_frame_period", 32'(e1 - e0), 32'((DW + 3) * CPB));
        compare_events("b2b");

        rx = 1'b0;
        e0 = cyc + 1;
        repeat (4) @(negedge clk);
        idle(START_EXIT + 10);
        chk_busy("false_busy_pre", e0 + 1, 1'b0);
        chk_busy("false_busy_rise", e0 + 2, 1'b1);
        chk_busy("false_busy_hold", e0 + START_EXIT - 1, 1'b1);
        chk_busy("false_busy_fall", e0 + START_EXIT, 1'b0);
        compare_events("false_start");

        rx = 1'b0;
        e0 = cyc + 1;
        repeat (400) @(negedge clk);
        exp_q.push_back('{cyc: e0 + LAT, frame: '0, err: 1'b1});
        last_frame = '0;
        idle(30);
        chk("break_busy_clear", 32'(busy), 32'h0);
        compare_events("break");
        send_frame(8'h5A, 1'b0, 1'b1, -1, e0);
        idle(4);
        compare_events("after_break");

        send_frame(8'hFA, 1'b1, 1'b1, 3, e0);
        idle(4);
        chk("rst_mid_busy", 32'(busy), 32'h0);
        compare_events("rst_mid");
        send_frame(8'h33, 1'b0, 1'b1, -1, e0);
        idle(4);
        compare_events("after_rst");

        prev_stop = 1'b1;
        for (int n = 0; n < 8; n++) begin
            gap = $urandom_range(0, 40);
            if (!prev_stop && gap < 2) gap = 2;
            idle(gap);
            d = DW'($urandom);
            p = 1'($urandom);
            s = ($urandom_range(0, 3) != 0);
            send_frame(d, p, s, -1, e0);
            prev_stop = s;
        end
        idle(6);
        compare_events("random");

        chk("valid_err_exclusive", 32'(both_cnt), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
